// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback buffer in front of the dual-write-port
// register file. Accepts one register write per cycle, drains up to two per
// cycle, and offers a lookup port so decode can forward pending writes.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready/in_reg/in_data push handshake (writes to reg 0 dropped)
//   wb_en                            drain permitted this cycle
//   rf_we1/rf_waddr1/rf_wdata1       register file port 1 (oldest entry)
//   rf_we2/rf_waddr2/rf_wdata2       register file port 2 (second oldest)
//   chk_reg/chk_hit/chk_data         pending-write lookup (newest match wins)
//   count, empty                     occupancy
module wb_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_en,
  output logic              rf_we1,
  output logic [ADDR_W-1:0] rf_waddr1,
  output logic [DATA_W-1:0] rf_wdata1,
  output logic              rf_we2,
  output logic [ADDR_W-1:0] rf_waddr2,
  output logic [DATA_W-1:0] rf_wdata2,
  input  logic [ADDR_W-1:0] chk_reg,
  output logic              chk_hit,
  output logic [DATA_W-1:0] chk_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] regMem  [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  e1Idx;
  logic              pushEn;
  logic [1:0]        popCnt;

  // Readiness looks at current occupancy only; a same-cycle drain does not help.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pushEn   = in_valid & in_ready & (in_reg != '0);
  assign e1Idx    = PTR_W'(rdPtr + PTR_W'(1));

  // Drain ports: port 2 yields when E1 targets the same register as E0 so the
  // older value can never overwrite the newer one in the register file.
  always_comb begin
    rf_we1    = 1'b0;
    rf_waddr1 = '0;
    rf_wdata1 = '0;
    rf_we2    = 1'b0;
    rf_waddr2 = '0;
    rf_wdata2 = '0;
    if (wb_en && (count >= CNT_W'(1))) begin
      rf_we1    = 1'b1;
      rf_waddr1 = regMem[rdPtr];
      rf_wdata1 = dataMem[rdPtr];
      if ((count >= CNT_W'(2)) && (regMem[e1Idx] != regMem[rdPtr])) begin
        rf_we2    = 1'b1;
        rf_waddr2 = regMem[e1Idx];
        rf_wdata2 = dataMem[e1Idx];
      end
    end
  end

  assign popCnt = {1'b0, rf_we1} + {1'b0, rf_we2};

  // Lookup walks oldest to newest so the last match left standing is the newest.
  always_comb begin
    logic [PTR_W-1:0] lkIdx;
    lkIdx    = '0;
    chk_hit  = 1'b0;
    chk_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lkIdx = PTR_W'(rdPtr + PTR_W'(i));
      if ((CNT_W'(i) < count) && (chk_reg != '0) && (regMem[lkIdx] == chk_reg)) begin
        chk_hit  = 1'b1;
        chk_data = dataMem[lkIdx];
      end
    end
  end

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regMem[i]  <= '0;
        dataMem[i] <= '0;
      end
    end else begin
      if (pushEn) begin
        regMem[wrPtr]  <= in_reg;
        dataMem[wrPtr] <= in_data;
        wrPtr          <= PTR_W'(wrPtr + PTR_W'(1));
      end
      rdPtr <= PTR_W'(rdPtr + PTR_W'(popCnt));
      count <= CNT_W'(count - CNT_W'(popCnt) + CNT_W'(pushEn));
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_wb_write_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;
  logic              wb_en;
  logic              rf_we1;
  logic [ADDR_W-1:0] rf_waddr1;
  logic [DATA_W-1:0] rf_wdata1;
  logic              rf_we2;
  logic [ADDR_W-1:0] rf_waddr2;
  logic [DATA_W-1:0] rf_wdata2;
  logic [ADDR_W-1:0] chk_reg;
  logic              chk_hit;
  logic [DATA_W-1:0] chk_data;
  logic [CNT_W-1:0]  count;
  logic              empty;

  ent_t mq[$];
  int   nChecks = 0;
  int   nPassed = 0;

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wb_en(wb_en),
    .rf_we1(rf_we1), .rf_waddr1(rf_waddr1), .rf_wdata1(rf_wdata1),
    .rf_we2(rf_we2), .rf_waddr2(rf_waddr2), .rf_wdata2(rf_wdata2),
    .chk_reg(chk_reg), .chk_hit(chk_hit), .chk_data(chk_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPassed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Compare every output against what the model's current contents imply.
  task automatic checkAll();
    int unsigned n;
    bit          e1, e2, hit;
    logic [DATA_W-1:0] hd;
    n   = mq.size();
    e1  = wb_en && (n >= 1);
    e2  = wb_en && (n >= 2) && (mq[1].r != mq[0].r);
    hit = 1'b0;
    hd  = '0;
    if (chk_reg != 0) begin
      for (int i = int'(n) - 1; i >= 0; i--) begin
        if (mq[i].r == chk_reg) begin
          hit = 1'b1;
          hd  = mq[i].d;
          break;
        end
      end
    end
    checkVal("count",    64'(count),     64'(n));
    checkVal("empty",    64'(empty),     64'(n == 0));
    checkVal("in_ready", 64'(in_ready),  64'(n < DEPTH));
    checkVal("we1",      64'(rf_we1),    64'(e1));
    checkVal("waddr1",   64'(rf_waddr1), e1 ? 64'(mq[0].r) : 64'd0);
    checkVal("wdata1",   64'(rf_wdata1), e1 ? 64'(mq[0].d) : 64'd0);
    checkVal("we2",      64'(rf_we2),    64'(e2));
    checkVal("waddr2",   64'(rf_waddr2), e2 ? 64'(mq[1].r) : 64'd0);
    checkVal("wdata2",   64'(rf_wdata2), e2 ? 64'(mq[1].d) : 64'd0);
    checkVal("chk_hit",  64'(chk_hit),   64'(hit));
    checkVal("chk_data", 64'(chk_data),  64'(hd));
  endtask

  // Model of one clock edge: drain first using the pre-edge contents, then push.
  task automatic modelEdge(input bit v, input logic [ADDR_W-1:0] r,
                           input logic [DATA_W-1:0] d, input bit wb);
    int unsigned n0;
    int unsigned pops;
    n0   = mq.size();
    pops = 0;
    if (wb && n0 >= 1) pops = 1;
    if (wb && n0 >= 2 && mq[1].r != mq[0].r) pops = 2;
    for (int unsigned k = 0; k < pops; k++) void'(mq.pop_front());
    if (v && n0 < DEPTH && r != 0) mq.push_back('{r: r, d: d});
  endtask

  // Drive one cycle of inputs, check at the falling edge, advance at the rising edge.
  task automatic cycle(input bit v, input logic [ADDR_W-1:0] r,
                       input logic [DATA_W-1:0] d, input bit wb,
                       input logic [ADDR_W-1:0] c);
    in_valid = v;
    in_reg   = r;
    in_data  = d;
    wb_en    = wb;
    chk_reg  = c;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    modelEdge(v, r, d, wb);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
    wb_en    = 1'b0;
    chk_reg  = '0;
    #3;
    checkVal("rst_count",   64'(count),   64'd0);
    checkVal("rst_empty",   64'(empty),   64'd1);
    checkVal("rst_ready",   64'(in_ready), 64'd1);
    checkVal("rst_we1",     64'(rf_we1),  64'd0);
    checkVal("rst_we2",     64'(rf_we2),  64'd0);
    checkVal("rst_chk_hit", 64'(chk_hit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write: visible on port 1 right after the push edge.
    cycle(1'b1, 5'd7, 32'hFEFDFBF7, 1'b1, 5'd0);
    checkVal("lat_we1",    64'(rf_we1),    64'd1);
    checkVal("lat_waddr1", 64'(rf_waddr1), 64'd7);
    checkVal("lat_wdata1", 64'(rf_wdata1), 64'hFEFDFBF7);
    checkVal("lat_we2",    64'(rf_we2),    64'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    checkVal("lat_empty",  64'(empty),     64'd1);

    // Fill while stalled, overflow push refused, then dual drain.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0);
    checkVal("full_count", 64'(count),    64'd4);
    checkVal("full_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd9);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    checkVal("drain_empty", 64'(empty), 64'd1);

    // Same-register pair: lookup returns newest, drain serialises.
    cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd0);
    cycle(1'b1, 5'd5, 32'h22, 1'b0, 5'd5);
    checkVal("dup_hit",  64'(chk_hit),  64'd1);
    checkVal("dup_data", 64'(chk_data), 64'h22);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5);

    // Writes to register 0 complete the handshake but are dropped.
    cycle(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0);
    checkVal("zero_count", 64'(count),   64'd0);
    checkVal("zero_hit",   64'(chk_hit), 64'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);

    // Async reset mid-cycle discards pending entries with no write issued.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 5'(i + 10), 32'(i), 1'b0, 5'd0);
    checkVal("pre_rst_count", 64'(count), 64'd3);
    wb_en = 1'b1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("arst_count", 64'(count),  64'd0);
    checkVal("arst_empty", 64'(empty),  64'd1);
    checkVal("arst_we1",   64'(rf_we1), 64'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd11);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd12);

    // Randomized traffic over a small register range to force collisions.
    for (int t = 0; t < 400; t++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 6)),
            32'($urandom),
            1'($urandom_range(0, 2) != 0),
            5'($urandom_range(0, 6)));
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
